fifo_uart_tx: RTL



---
 rtl/fifo_uart_pkg.sv | 6 +
 rtl/fifo_uart_tx_if.sv | 8 +
 rtl/uart_baud_cnt.sv | 21 ++
 rtl/fifo_uart_tx.sv | 114 +++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;
  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PAR, STOP} state_t;
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read side of the byte FIFO as seen by the transmitter.
interface fifo_uart_tx_if;
  logic       fifo_e;
  logic [7:0] fifo_dout;
  logic       fifo_re;
  modport master (input fifo_e, input fifo_dout, output fifo_re);
  modport slave  (output fifo_e, output fifo_dout, input fifo_re);
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles, pulses bit_done on the last one.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_done
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                   cnt <= '0;
    else if (clr || cnt == LAST)  cnt <= '0;
    else                          cnt <= cnt + 1'b1;

  assign bit_done = (cnt == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO and serialises each byte: start, 8 data LSB first, optional even parity, stop.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_uart_tx_if.master  bus,
  output logic            tx,
  output logic            busy
);
  state_t                 state_q, state_d;
  logic                   fifo_re_q, fifo_re_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic                   par_q, par_d;
  logic                   clr, bit_done;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      fifo_re_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      idx_q     <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_re_q <= fifo_re_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      par_q     <= par_d;
    end

  // Counter is held at zero until the start bit so every bit period is exact.
  always_comb begin
    state_d   = state_q;
    fifo_re_d = 1'b0;
    tx_d      = tx_q;
    busy_d    = busy_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    par_d     = par_q;
    clr       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (!bus.fifo_e) begin
          fifo_re_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        clr     = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        clr     = 1'b1;
        shift_d = bus.fifo_dout;
        par_d   = ^bus.fifo_dout;
        idx_d   = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: if (bit_done) begin
        tx_d    = shift_q[0];
        state_d = DATA;
      end
      DATA: if (bit_done) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'(DATA_BITS - 1)) begin
          if (PARITY_EN != 0) begin
            tx_d    = par_q;
            state_d = PAR;
          end else begin
            tx_d    = IDLE_LEVEL;
            state_d = STOP;
          end
        end else begin
          tx_d = shift_q[1];
        end
      end
      PAR: if (bit_done) begin
        tx_d    = IDLE_LEVEL;
        state_d = STOP;
      end
      STOP: if (bit_done) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fifo_re = fifo_re_q;
  assign tx          = tx_q;
  assign busy        = busy_q;
endmodule
